// File: rtl/pdemux_route.sv
// Priority demultiplexer with a one-entry input stage and eight buffered
// output channels, each with its own valid/ready handshake.
module pdemux_route #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 32,
  parameter int DROP_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [SEL_W-1:0]    sel_0_i,
  input  logic [SEL_W-1:0]    sel_1_i,
  input  logic [SEL_W-1:0]    sel_2_i,
  input  logic [SEL_W-1:0]    sel_3_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [8*DATA_W-1:0] q_o,
  output logic [7:0]          valid_o,
  input  logic [7:0]          ready_i,
  output logic [DROP_W-1:0]   drop_cnt_o,
  output logic                busy_o
);

  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]   s1_data_q;
  logic [SEL_W-1:0]    s1_sel0_q, s1_sel1_q;
  logic [SEL_W-1:0]    s1_sel2_q, s1_sel3_q;
  logic [7:0]          vld_q, vld_d;
  logic [8*DATA_W-1:0] q_q, q_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic       hit;
  logic [2:0] tgt;
  logic       s1_move;
  logic       accept;

  // Ordered chain: the first matching rule selects the channel.
  always_comb begin
    hit = 1'b1;
    tgt = 3'd0;
    if (s1_sel0_q == SEL_W'(0))       tgt = 3'd0;
    else if (s1_sel1_q == SEL_W'(10)) tgt = 3'd1;
    else if (s1_sel2_q == SEL_W'(21)) tgt = 3'd2;
    else if (s1_sel3_q == SEL_W'(77)) tgt = 3'd3;
    else if (s1_sel0_q == SEL_W'(50)) tgt = 3'd4;
    else if (s1_sel1_q == SEL_W'(60)) tgt = 3'd5;
    else if (s1_sel2_q == SEL_W'(70)) tgt = 3'd6;
    else if (s1_sel3_q == SEL_W'(80)) tgt = 3'd7;
    else                              hit = 1'b0;
  end

  assign s1_move = s1_valid_q &&
                   (!hit || !vld_q[tgt] || ready_i[tgt]);
  assign ready_o = !s1_valid_q || s1_move;
  assign accept  = valid_i && ready_o;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (s1_move) s1_valid_d = 1'b0;
  end

  // Drain first, then a landing word re-sets the same channel.
  always_comb begin
    vld_d  = vld_q & ~ready_i;
    q_d    = q_q;
    drop_d = drop_q;
    if (s1_move && hit) begin
      vld_d[tgt]                 = 1'b1;
      q_d[tgt*DATA_W +: DATA_W]  = s1_data_q;
    end
    if (s1_move && !hit && (drop_q != '1))
      drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      vld_q      <= '0;
      q_q        <= '0;
      drop_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      vld_q      <= vld_d;
      q_q        <= q_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_data_q <= data_i;
      s1_sel0_q <= sel_0_i;
      s1_sel1_q <= sel_1_i;
      s1_sel2_q <= sel_2_i;
      s1_sel3_q <= sel_3_i;
    end
  end

  assign q_o        = q_q;
  assign valid_o    = vld_q;
  assign drop_cnt_o = drop_q;
  assign busy_o     = s1_valid_q || (|vld_q);

endmodule

// File: tb/tb_pdemux_route.sv
// Scoreboard bench for pdemux_route: per-channel expected queues filled on
// accept, drained by a monitor on each channel handshake.
module tb_pdemux_route;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [31:0]  sel_0_i, sel_1_i, sel_2_i, sel_3_i;
  logic [15:0]  data_i;
  logic [127:0] q_o;
  logic [7:0]   valid_o;
  logic [7:0]   ready_i;
  logic [7:0]   drop_cnt_o;
  logic         busy_o;

  pdemux_route dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sel_0_i    (sel_0_i),
    .sel_1_i    (sel_1_i),
    .sel_2_i    (sel_2_i),
    .sel_3_i    (sel_3_i),
    .data_i     (data_i),
    .q_o        (q_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .drop_cnt_o (drop_cnt_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  logic [15:0] expq [8][$];
  int          drop_m = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every channel handshake must match the queue head.
  always @(negedge clk) begin
    if (!rst_i) begin
      for (int k = 0; k < 8; k++) begin
        if (valid_o[k] && ready_i[k]) begin
          if (expq[k].size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexp_ch%0d: got %0h expected none",
                     k, q_o[k*16 +: 16]);
          end else begin
            chk($sformatf("ch%0d_data", k), 128'(q_o[k*16 +: 16]),
                128'(expq[k].pop_front()));
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] s3,
                      input logic [15:0] d, input int ch,
                      output int w);
    sel_0_i = s0;
    sel_1_i = s1;
    sel_2_i = s2;
    sel_3_i = s3;
    data_i  = d;
    valid_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 40) begin
      w++;
      @(negedge clk);
    end
    if (!ready_o) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got ready_o=0 expected 1");
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    if (ch >= 0) expq[ch].push_back(d);
    else if (drop_m != 255) drop_m++;
    #1 valid_i = 1'b0;
  endtask

  int w;
  int maxw;
  int left;

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 8'h00;
    sel_0_i = 32'd1;
    sel_1_i = 32'd1;
    sel_2_i = 32'd1;
    sel_3_i = 32'd1;
    data_i  = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(valid_o), 128'h0);
    chk("rst_q", q_o, 128'h0);
    chk("rst_drop", 128'(drop_cnt_o), 128'h0);
    chk("rst_busy", 128'(busy_o), 128'h0);
    chk("rst_ready", 128'(ready_o), 128'h1);

    // Basic routing to ch0
    @(posedge clk); #1;
    send(32'd0, 32'd1, 32'd1, 32'd1, 16'h1234, 0, w);
    @(negedge clk);
    chk("basic_s1_valid", 128'(valid_o), 128'h0);
    chk("basic_s1_busy", 128'(busy_o), 128'h1);
    @(negedge clk);
    chk("basic_valid", 128'(valid_o), 128'h01);
    chk("basic_q0", 128'(q_o[15:0]), 128'h1234);
    repeat (3) @(negedge clk);
    chk("basic_hold", 128'(valid_o), 128'h01);
    @(posedge clk); #1 ready_i = 8'h01;
    @(posedge clk); #1 ready_i = 8'h00;
    @(negedge clk);
    chk("basic_drained", 128'(valid_o), 128'h0);

    // Priority: rule 1 beats rule 4
    @(posedge clk); #1;
    send(32'd50, 32'd10, 32'd1, 32'd1, 16'hBEEF, 1, w);
    repeat (2) @(negedge clk);
    chk("prio_valid", 128'(valid_o), 128'h02);
    chk("prio_q1", 128'(q_o[31:16]), 128'hBEEF);
    @(posedge clk); #1 ready_i = 8'h02;
    @(posedge clk); #1 ready_i = 8'h00;

    // Drops and saturation
    maxw = 0;
    for (int i = 0; i < 10; i++) begin
      send(32'd5, 32'd5, 32'd5, 32'd5, 16'(i), -1, w);
      if (w > maxw) maxw = w;
    end
    repeat (2) @(negedge clk);
    chk("drop_10", 128'(drop_cnt_o), 128'(drop_m));
    @(posedge clk); #1;
    for (int i = 0; i < 290; i++) begin
      send(32'd5, 32'd5, 32'd5, 32'd5, 16'(i), -1, w);
      if (w > maxw) maxw = w;
    end
    repeat (2) @(negedge clk);
    chk("drop_ready_stall", 128'(maxw), 128'h0);
    chk("drop_sat", 128'(drop_cnt_o), 128'd255);
    chk("drop_model", 128'(drop_m), 128'd255);
    chk("drop_novalid", 128'(valid_o), 128'h0);

    // Backpressure on ch7
    @(posedge clk); #1;
    send(32'd1, 32'd1, 32'd1, 32'd80, 16'hA001, 7, w);
    send(32'd1, 32'd1, 32'd1, 32'd80, 16'hA002, 7, w);
    @(negedge clk);
    chk("bp_ready0", 128'(ready_o), 128'h0);
    chk("bp_valid", 128'(valid_o), 128'h80);
    sel_0_i = 32'd1;
    sel_1_i = 32'd1;
    sel_2_i = 32'd21;
    sel_3_i = 32'd1;
    data_i  = 16'hC003;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_block%0d", i), 128'(ready_o), 128'h0);
    end
    @(posedge clk); #1 ready_i = 8'h80;
    @(negedge clk);
    chk("bp_ready1", 128'(ready_o), 128'h1);
    @(posedge clk);
    expq[2].push_back(16'hC003);
    #1 ready_i = 8'h00;
    valid_i = 1'b0;
    @(negedge clk);
    chk("bp_refill", 128'(valid_o), 128'h80);
    chk("bp_q7", 128'(q_o[127:112]), 128'hA002);
    @(negedge clk);
    chk("bp_ch2", 128'(valid_o), 128'h84);
    @(posedge clk); #1 ready_i = 8'hFF;
    repeat (3) @(negedge clk);
    chk("bp_empty", 128'(valid_o), 128'h0);

    // Streaming alternating ch3/ch5, all ready
    @(posedge clk); #1;
    maxw = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        send(32'd1, 32'd1, 32'd1, 32'd77, 16'h3000 + 16'(i), 3, w);
      else
        send(32'd1, 32'd60, 32'd1, 32'd1, 16'h5000 + 16'(i), 5, w);
      if (w > maxw) maxw = w;
    end
    repeat (3) @(negedge clk);
    chk("stream_rate", 128'(maxw), 128'h0);
    chk("stream_empty", 128'(valid_o), 128'h0);

    // Async reset with ch6 full and S1 loaded
    @(posedge clk); #1 ready_i = 8'h00;
    send(32'd1, 32'd1, 32'd70, 32'd1, 16'h6666, 6, w);
    send(32'd1, 32'd1, 32'd70, 32'd1, 16'h6667, 6, w);
    @(negedge clk);
    chk("pre_rst_valid", 128'(valid_o), 128'h40);
    chk("pre_rst_ready", 128'(ready_o), 128'h0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", 128'(valid_o), 128'h0);
    chk("arst_q", q_o, 128'h0);
    chk("arst_drop", 128'(drop_cnt_o), 128'h0);
    chk("arst_busy", 128'(busy_o), 128'h0);
    chk("arst_ready", 128'(ready_o), 128'h1);
    for (int k = 0; k < 8; k++) expq[k].delete();
    drop_m = 0;
    @(posedge clk); #1 rst_i = 1'b0;

    // Counter restarts from zero
    send(32'd5, 32'd5, 32'd5, 32'd5, 16'h0, -1, w);
    repeat (2) @(negedge clk);
    chk("post_rst_drop", 128'(drop_cnt_o), 128'(drop_m));

    left = 0;
    for (int k = 0; k < 8; k++) left += expq[k].size();
    chk("sb_empty", 128'(left), 128'h0);
    chk("final_busy", 128'(busy_o), 128'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
